axicb_resp_router: RTL
======================

Name: axicb_resp_router

Overview:
- Response-side companion to the crossbar round-robin arbiter.
- Records the one-hot grant index of every address phase accepted by a slave, in an in-order tracking FIFO.
- Routes the slave's response beats back to the originating master, strictly in request order.
- One instance sits on each slave port, per channel pair (AW→B, AR→R).

Parameters:
- REQ_NB, 4: number of masters; width of grant and of the per-master response ports.
- DATA_W, 32: response payload width (R data plus resp bits, or B resp bits).
- OSTDREQ_NUM, 4: maximum outstanding requests tracked; FIFO depth; power of two, ≥2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset; same effect as aresetn
- grant  in  REQ_NB  one-hot grant from the arbiter, valid with a_valid
- a_valid  in  1  arbitrated address phase valid toward the slave
- a_ready_in  in  1  slave address ready
- a_ready_out  out  1  address ready returned to the arbitrated master: a_ready_in & ~full
- s_valid  in  1  slave response valid
- s_ready  out  1  slave response ready
- s_last  in  1  last beat of the response; tie to 1 for B channel
- s_data  in  DATA_W  slave response payload
- m_valid  out  REQ_NB  per-master response valid
- m_ready  in  REQ_NB  per-master response ready
- m_data  out  DATA_W  payload broadcast to all masters, equal to s_data
- m_last  out  1  equal to s_last
- err  out  1  sticky protocol error flag (optional feature)

Behaviour:
- Storage: FIFO of OSTDREQ_NUM entries, each $clog2(REQ_NB) bits wide, with wptr/rptr and a count of width $clog2(OSTDREQ_NUM)+1.
- full = (count == OSTDREQ_NUM); empty = (count == 0).
- Reset (aresetn low, or srst high on a clock edge):
  - wptr, rptr, count = 0; err = 0; m_valid = 0; s_ready = 0.
  - a_ready_out follows a_ready_in, since full = 0.
- Push: on a clock edge with a_valid & a_ready_out, write the index of grant into the FIFO.
  - Index = lowest set bit of grant; all-zero grant gives index 0.
  - wptr wraps modulo OSTDREQ_NUM.
- Routing is combinational from the FIFO head (idx = mem[rptr]), with no bypass:
  - m_valid[i] = s_valid & ~empty & (i == idx).
  - s_ready = ~empty & m_ready[idx].
- Latency: a request pushed at edge N can be routed from cycle N+1 onward. A response arriving while the FIFO is empty is held, with s_ready = 0, until an entry exists.
- Pop: on a clock edge with s_valid & s_ready & s_last, rptr increments (wrapping). Non-last beats do not pop.
- Count update:
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
- Full boundary: a_ready_out = 0 while full, even if a pop occurs in the same cycle; no push-through.
- Reset mid-burst drops all tracked entries; the upstream side is also reset by the same aresetn/srst.
- m_valid is never multi-hot. m_data and m_last are driven unconditionally.

Optional Feature:
- Macro AXICB_RESP_ERR_CHECK_EN.
- Defined: err is set on any edge where either condition holds; err clears only on reset.
  - A push with grant not one-hot (zero or multi-hot).
  - s_valid held while empty for more than 1 cycle, with the wait counter restarting each time the FIFO becomes non-empty.
- Undefined: err tied to 0; no checker logic synthesised.

Test Plan:
- Order: push grant=4'b0010, then 4'b1000 with a_ready_in=1; send s_valid,s_last=1 with s_data=0xA5, then 0x5A → m_valid=4'b0010 carries 0xA5, then m_valid=4'b1000 carries 0x5A; count returns to 0.
- Burst: push grant=4'b0100; 4 beats with s_last on the 4th; m_ready[2] toggling 1,0,1,… → s_ready mirrors m_ready[2]; pop only on the 4th accepted beat; rptr advances by 1.
- Full: OSTDREQ_NUM=4, push 4 requests with no responses → a_ready_out=0 on the 5th a_valid. A pop in the same cycle as a 5th a_valid still yields a_ready_out=0; the push is accepted the next cycle.
- Simultaneous: count=2 with a push and a pop on the same edge → count stays 2; the next head is the correct index.
- Empty: s_valid=1 with no entries → s_ready=0 and m_valid=0. Push grant=4'b0001 at edge N → m_valid[0]=1 in cycle N+1.
- With AXICB_RESP_ERR_CHECK_EN: push grant=4'b0011 → err=1 next cycle and stays 1 until aresetn low. Without the macro, err=0.

Source files
------------

// File: rtl/axicb_resp_router.sv
// rtl/axicb_resp_router.sv - in-order response router for one crossbar slave port
//
// Records the arbiter's grant index for every address phase the slave
// accepts, then steers the slave's response beats back to that master in
// request order. Instantiate once per slave port and channel pair (AW->B,
// AR->R).
//
// Optional feature: define AXICB_RESP_ERR_CHECK_EN to build the sticky
// protocol checker behind err. Without it err is tied low.
//
// Ports:
//   aclk, aresetn, srst      clock, async active-low reset, sync active-high reset
//   grant[REQ_NB]            one-hot grant from the arbiter, valid with a_valid
//   a_valid, a_ready_in      arbitrated address handshake toward the slave
//   a_ready_out              address ready back to the master (a_ready_in & ~full)
//   s_valid/s_ready/s_last   slave response handshake and last-beat marker
//   s_data[DATA_W]           slave response payload
//   m_valid/m_ready[REQ_NB]  per-master response handshake
//   m_data, m_last           payload and last flag broadcast to all masters
//   err                      sticky protocol error flag

module axicb_resp_router #(
    parameter int REQ_NB      = 4,
    parameter int DATA_W      = 32,
    parameter int OSTDREQ_NUM = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic [REQ_NB-1:0] grant,
    input  logic              a_valid,
    input  logic              a_ready_in,
    output logic              a_ready_out,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    output logic [REQ_NB-1:0] m_valid,
    input  logic [REQ_NB-1:0] m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              err
);

    localparam int IDX_W = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
    localparam int PTR_W = (OSTDREQ_NUM > 1) ? $clog2(OSTDREQ_NUM) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] mem_q [OSTDREQ_NUM];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] head_idx;

    assign full  = (count_q == CNT_W'(OSTDREQ_NUM));
    assign empty = (count_q == '0);

    // Full blocks the push even if a pop lands on the same edge: the ready
    // path stays a pure function of registered state, no push-through.
    assign a_ready_out = a_ready_in & ~full;

    assign push = a_valid & a_ready_out;
    assign pop  = s_valid & s_ready & s_last;

    // Lowest set bit wins; an all-zero grant records master 0.
    always_comb begin
        grant_idx = '0;
        for (int i = REQ_NB - 1; i >= 0; i--) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Routing reads the registered head only; a request pushed this cycle
    // becomes visible next cycle.
    assign head_idx = mem_q[rptr_q];

    always_comb begin
        m_valid = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (IDX_W'(i) == head_idx) begin
                m_valid[i] = s_valid & ~empty;
            end
        end
    end

    assign s_ready = ~empty & m_ready[head_idx];
    assign m_data  = s_data;
    assign m_last  = s_last;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < OSTDREQ_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (srst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < OSTDREQ_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wptr_q] <= grant_idx;
            end
        end
    end

`ifdef AXICB_RESP_ERR_CHECK_EN
    // wait_q marks that s_valid was already pending against an empty FIFO on
    // the previous cycle; a second consecutive such cycle is an error. It
    // restarts whenever the FIFO holds an entry or s_valid drops.
    logic wait_q, wait_d;
    logic err_q, err_d;

    always_comb begin
        wait_d = s_valid & empty;
        err_d  = err_q;
        if (push && !$onehot(grant)) begin
            err_d = 1'b1;
        end
        if (s_valid && empty && wait_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wait_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (srst) begin
            wait_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
